// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard unit: per-register pending-write scoreboard, load-use stalls,
// operand forward selects, redirect flush window and a saturating stall-cycle counter.
module hazard_scoreboard #(
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 2,
  parameter int FLUSH_DEPTH = 2,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic              issue_use_rs1,
  input  logic              issue_use_rs2,
  input  logic              issue_wr,
  input  logic              issue_load,
  input  logic              redirect,
  input  logic              ext_stall,
  output logic              stall,
  output logic              flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int NREG = 1 << REG_AW;
  localparam int CW   = $clog2(LOAD_LAT + 1);
  localparam int FCW  = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

  localparam logic [CW-1:0]  LOAD_CNT     = CW'(LOAD_LAT);
  localparam logic [CW-1:0]  ALU_CNT      = CW'(1);
  localparam logic [FCW-1:0] FLUSH_RELOAD = FCW'(FLUSH_DEPTH - 1);

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_ALU = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  logic [CW-1:0]     r_cnt [NREG];
  logic              r_ld  [NREG];
  logic [FCW-1:0]    r_flush_cnt;
  logic [PERF_W-1:0] r_perf;

  logic       w_haz_a, w_haz_b;
  logic [1:0] w_fwd_a, w_fwd_b;
  logic       w_flush, w_stall, w_accept, w_set;

  // Hazard and forward decisions read the pre-update scoreboard, so rd == rs sees the older writer.
  always_comb begin
    w_haz_a = 1'b0;
    w_haz_b = 1'b0;
    w_fwd_a = FWD_RF;
    w_fwd_b = FWD_RF;
    if (issue_use_rs1 && (issue_rs1 != '0)) begin
      w_haz_a = (r_cnt[issue_rs1] > ALU_CNT) && r_ld[issue_rs1];
      if (r_cnt[issue_rs1] == ALU_CNT) w_fwd_a = r_ld[issue_rs1] ? FWD_MEM : FWD_ALU;
    end
    if (issue_use_rs2 && (issue_rs2 != '0)) begin
      w_haz_b = (r_cnt[issue_rs2] > ALU_CNT) && r_ld[issue_rs2];
      if (r_cnt[issue_rs2] == ALU_CNT) w_fwd_b = r_ld[issue_rs2] ? FWD_MEM : FWD_ALU;
    end
  end

  assign w_flush  = redirect | (r_flush_cnt != '0);
  assign w_stall  = ext_stall | (issue_valid & ~w_flush & (w_haz_a | w_haz_b));
  assign w_accept = issue_valid & ~w_stall & ~w_flush;
  assign w_set    = w_accept & issue_wr & (issue_rd != '0);

  assign stall        = rst_n & w_stall;
  assign flush        = rst_n & w_flush;
  assign fwd_a        = rst_n ? w_fwd_a : FWD_RF;
  assign fwd_b        = rst_n ? w_fwd_b : FWD_RF;
  assign stall_cycles = r_perf;

  // NOTE: the scoreboard array is reset explicitly; stale pending counts after reset would stall or mis-forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_cnt[i] <= '0;
        r_ld[i]  <= 1'b0;
      end
    end else if (!ext_stall) begin
      for (int i = 0; i < NREG; i++) begin
        if (w_set && (issue_rd == REG_AW'(i))) begin
          r_cnt[i] <= issue_load ? LOAD_CNT : ALU_CNT;
          r_ld[i]  <= issue_load;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - ALU_CNT;
        end
      end
    end
  end

  // Flush window and perf counter keep running through external stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush_cnt <= '0;
      r_perf      <= '0;
    end else begin
      if (redirect)                r_flush_cnt <= FLUSH_RELOAD;
      else if (r_flush_cnt != '0)  r_flush_cnt <= r_flush_cnt - FCW'(1);
      if (w_stall && (r_perf != '1)) r_perf <= r_perf + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (default parameters: LOAD_LAT = 2, FLUSH_DEPTH = 2).
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_use_rs1, issue_use_rs2, issue_wr, issue_load;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        redirect, ext_stall;
  logic        stall, flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_wr(issue_wr), .issue_load(issue_load),
    .redirect(redirect), .ext_stall(ext_stall),
    .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic s, input logic f,
                      input logic [1:0] a, input logic [1:0] b);
    check({tag, ".stall"}, 32'(stall), 32'(s));
    check({tag, ".flush"}, 32'(flush), 32'(f));
    check({tag, ".fwd_a"}, 32'(fwd_a), 32'(a));
    check({tag, ".fwd_b"}, 32'(fwd_b), 32'(b));
  endtask

  // valid, rd, rs1, rs2, use_rs1, use_rs2, wr, load
  task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic wr, input logic ld);
    issue_valid = v; issue_rd = rd; issue_rs1 = r1; issue_rs2 = r2;
    issue_use_rs1 = u1; issue_use_rs2 = u2; issue_wr = wr; issue_load = ld;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock; inputs are driven and outputs sampled around the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; ext_stall = 1'b0;
    idle();
    step();
    outs("por", 0, 0, 0, 0);
    check("por.perf", stall_cycles, 0);
    rst_n = 1'b1;
    step();

    // 1. reset mid-stream with cnt[5] = 2 and a flush in progress
    drive(1, 5, 0, 0, 0, 0, 1, 1);          // LW x5
    #1 outs("t1.lw", 0, 0, 0, 0);
    step();
    idle(); redirect = 1'b1;
    drive(0, 0, 5, 0, 1, 0, 0, 0);
    #1 check("t1.redir_flush", 32'(flush), 1);
    rst_n = 1'b0;
    drive(1, 0, 5, 0, 1, 0, 0, 0);
    #1 outs("t1.in_reset", 0, 0, 0, 0);
    check("t1.perf_reset", stall_cycles, 0);
    step();
    redirect = 1'b0;
    rst_n = 1'b1;
    #1 outs("t1.after_release", 0, 0, 0, 0);
    step();

    // 2. ALU producer -> consumer forwards from X next cycle, then regfile
    drive(1, 3, 1, 2, 1, 1, 1, 0);          // ADD x3
    #1 outs("t2.add", 0, 0, 0, 0);
    step();
    drive(1, 0, 3, 0, 1, 0, 0, 0);          // SUB reads x3
    #1 outs("t2.sub", 0, 0, 1, 0);
    step();
    #1 outs("t2.third", 0, 0, 0, 0);
    step();

    // 3. load-use: one stall cycle, then MEM forward
    drive(1, 4, 0, 0, 0, 0, 1, 1);          // LW x4
    step();
    drive(1, 0, 0, 4, 0, 1, 0, 0);          // ADD rs2 = x4
    #1 outs("t3.stall", 1, 0, 0, 0);
    check("t3.perf0", stall_cycles, 0);
    step();
    outs("t3.fwd_mem", 0, 0, 0, 2);
    check("t3.perf1", stall_cycles, 1);
    step();

    // 4. WAW: ALU write after load wins, no load stall for the reader
    drive(1, 6, 0, 0, 0, 0, 1, 1);          // LW x6
    step();
    drive(1, 6, 0, 0, 0, 0, 1, 0);          // ADD x6
    #1 outs("t4.add", 0, 0, 0, 0);
    step();
    drive(1, 0, 6, 6, 1, 1, 0, 0);
    #1 outs("t4.reader", 0, 0, 1, 1);
    step();

    // 5. redirect squashes LW x7; second redirect extends the window
    redirect = 1'b1;
    drive(1, 7, 0, 0, 0, 0, 1, 1);
    #1 outs("t5.t0", 0, 1, 0, 0);
    step();
    idle();
    #1 outs("t5.t1", 0, 1, 0, 0);
    step();
    redirect = 1'b0;
    #1 outs("t5.t2", 0, 1, 0, 0);
    step();
    drive(1, 0, 7, 7, 1, 1, 0, 0);
    #1 outs("t5.t3_x7_clean", 0, 0, 0, 0);
    step();

    // 6. ext_stall freezes the scoreboard but counts cycles
    drive(1, 9, 0, 0, 0, 0, 1, 1);          // LW x9
    step();
    ext_stall = 1'b1;
    drive(1, 0, 9, 0, 1, 0, 0, 0);
    #1 outs("t6.frz0", 1, 0, 0, 0);
    check("t6.perf_a", stall_cycles, 1);
    step();
    outs("t6.frz1", 1, 0, 0, 0);
    step();
    outs("t6.frz2", 1, 0, 0, 0);
    step();
    ext_stall = 1'b0;
    #1 outs("t6.thaw_hazard", 1, 0, 0, 0);
    check("t6.perf_b", stall_cycles, 4);
    step();
    outs("t6.fwd_mem", 0, 0, 2, 0);
    check("t6.perf_c", stall_cycles, 5);
    step();

    // x0 is never tracked
    drive(1, 0, 0, 0, 0, 0, 1, 1);          // LW x0
    step();
    drive(1, 0, 0, 0, 1, 1, 0, 0);
    #1 outs("x0.reader", 0, 0, 0, 0);
    step();
    idle();
    #1 check("end.perf", stall_cycles, 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
